// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the nibble-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  localparam int NIBBLES_DEF = 4;

endpackage

// File: rtl/nibble_add4.sv
// 4-bit ripple adder slice shared by all nibble positions of the serial adder.
module nibble_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign sum  = full[3:0];
  assign cout = full[4];

endmodule

// File: rtl/serial_add_ctrl.sv
// Nibble-serial adder: one shared 4-bit slice, LSB nibble first, carry held in a flop.
// Optional subtract support is enabled by defining SERIAL_SUB_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] x,
  input  logic [4*NIBBLES-1:0] y,
`ifdef SERIAL_SUB_EN
  input  logic                 sub,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] s,
  output logic                 c_out
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [W-1:0]  xr, yr;
  logic          carry;
  logic [3:0]    slice_sum;
  logic          slice_cout;

  nibble_add4 u_slice (
    .a    (xr[{cnt, 2'b00} +: 4]),
    .b    (yr[{cnt, 2'b00} +: 4]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = ADD;
      end
      ADD:  if (cnt == LAST) state_nx = DONE;
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // s is only written nibble by nibble, so the previous result persists until the next ADD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr    <= '0;
      yr    <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      s     <= '0;
      c_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          xr  <= x;
          cnt <= '0;
`ifdef SERIAL_SUB_EN
          yr    <= sub ? ~y : y;
          carry <= sub;
`else
          yr    <= y;
          carry <= 1'b0;
`endif
        end
        ADD: begin
          s[{cnt, 2'b00} +: 4] <= slice_sum;
          if (cnt == LAST) begin
            c_out <= slice_cout;
          end else begin
            carry <= slice_cout;
            cnt   <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the operand width as NIBBLES x 4 bits; legal range is 2 to 16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: operation request.
REQ-005 The block SHALL have port x, input, 4*NIBBLES bits: operand A.
REQ-006 The block SHALL have port y, input, 4*NIBBLES bits: operand B.
REQ-007 The block SHALL have port sub, input, 1 bit: subtract request; it exists only when SERIAL_SUB_EN is defined.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port s, output, 4*NIBBLES bits: the result.
REQ-011 The block SHALL have port c_out, output, 1 bit: the final carry out of the MSB nibble.

Function
REQ-012 The block SHALL compute x+y using one shared 4-bit adder slice, one nibble per cycle, LSB nibble first.
REQ-013 The FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-014 In IDLE, start=1 at a rising edge SHALL capture x, y (and sub) into internal registers, clear the nibble counter to 0, load the carry flop with 0, and move to ADD.
REQ-015 In ADD, each edge SHALL write slice sum bits into s[4*cnt+3:4*cnt], update the carry flop with the slice carry and increment cnt.
REQ-016 When cnt=NIBBLES-1, that edge SHALL instead move to DONE and load c_out with the slice carry.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, and the next edge SHALL return to IDLE unconditionally.
REQ-018 The done pulse SHALL be visible NIBBLES edges after the accepting edge; the next start SHALL be accepted no earlier than the cycle after done.
REQ-019 start SHALL be ignored while busy=1, including the DONE cycle; captured operands SHALL not change mid-operation even if x or y toggle.
REQ-020 s and c_out SHALL hold their last value from the DONE cycle until the next accepted start begins overwriting nibble 0.
REQ-021 Carry SHALL propagate across nibble boundaries through the carry flop only; s wraps modulo 2^(4*NIBBLES), and the overflow bit appears only on c_out.

Reset
REQ-022 rst=1 SHALL immediately force state=IDLE, cnt=0, carry flop=0, busy=0, done=0, s=0 and c_out=0, including when asserted mid-ADD; the aborted operation SHALL produce no done pulse.
REQ-023 After rst deasserts, the first start SHALL be accepted at the first rising edge at which it is sampled high.

Configuration
REQ-024 The macro SERIAL_SUB_EN SHALL control subtract support.
REQ-025 With SERIAL_SUB_EN defined, the sub port SHALL exist; sub=1 captured at start SHALL invert the captured y and load the carry flop with 1, computing x-y in two's complement, with c_out=1 meaning no borrow.
REQ-026 Without SERIAL_SUB_EN, the sub port and inversion logic SHALL be absent, and the block SHALL always add with carry-in 0.

Structure
REQ-027 The state enum type (IDLE/ADD/DONE) and the default NIBBLES constant SHALL reside in the shared package serial_add_pkg.
REQ-028 The 4-bit slice SHALL be a separate sub-module, nibble_add4 (a, b, cin -> sum[3:0], cout), instantiated exactly once.
REQ-029 The counter width SHALL be $clog2(NIBBLES).

Verification
REQ-030 Add, no carry: NIBBLES=4, x=16'h1234, y=16'h4321, start -> done after 4 edges, s=16'h5555, c_out=0.
REQ-031 Full ripple: x=16'hFFFF, y=16'h0001 -> s=16'h0000, c_out=1, with carry crossing all nibble boundaries.
REQ-032 Busy and operand holding: start pulsed again mid-ADD and in DONE with new x/y -> ignored; result matches the first operands; only one done pulse.
REQ-033 Reset mid-op: rst asserted in the second ADD cycle -> all outputs 0 immediately, no done pulse; a new start with 16'h0F0F+16'h00F1 -> s=16'h1000, c_out=0.
REQ-034 SERIAL_SUB_EN: x=16'h0005, y=16'h0007, sub=1 -> s=16'hFFFE, c_out=0; x=16'h0007, y=16'h0005 -> s=16'h0002, c_out=1.
REQ-035 Back-to-back: start held high continuously -> operations accepted every NIBBLES+2 cycles, each done exactly one cycle wide.
